// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared read-source, region and FSM state types for the 65C02 bus sequencer
package bus_pkg;

    typedef enum logic [2:0] {
        SEL_NONE = 3'd0,
        SEL_RAM  = 3'd1,
        SEL_ROM  = 3'd2,
        SEL_ACIA = 3'd3,
        SEL_VIA  = 3'd4,
        SEL_EXT  = 3'd5
    } bus_sel_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_VIA = 2'd1,
        ST_WAIT_EXT = 2'd2
    } bus_state_t;

    localparam logic [15:0] ROM_BASE  = 16'hC000;
    localparam logic [15:0] RAM_TOP   = 16'h7FFF;
    localparam logic [15:0] ACIA_BASE = 16'h8000;
    localparam logic [15:0] ACIA_LAST = 16'h800F;
    localparam logic [15:0] VIA_BASE  = 16'h8800;
    localparam logic [15:0] VIA_LAST  = 16'h880F;

endpackage

// File: rtl/bus_decode.sv
// rtl/bus_decode.sv - combinational CPU address to bus region decode
module bus_decode
    import bus_pkg::*;
(
    input  logic [15:0] addr,
    output bus_sel_t    sel
);

    // Priority order only matters for readability: the regions never overlap.
    always_comb begin
        if (addr >= ROM_BASE) begin
            sel = SEL_ROM;
        end else if (addr <= RAM_TOP) begin
            sel = SEL_RAM;
        end else if (addr >= ACIA_BASE && addr <= ACIA_LAST) begin
            sel = SEL_ACIA;
        end else if (addr >= VIA_BASE && addr <= VIA_LAST) begin
            sel = SEL_VIA;
        end else begin
            sel = SEL_EXT;
        end
    end

endmodule

// File: rtl/bus_ctrl_65c02.sv
// rtl/bus_ctrl_65c02.sv - 65C02 bus sequencer: chip selects, VIA phase-2 enable, RDY wait states, read-mux select
// Define BUS_TIMEOUT_EN to abort stalled external accesses after TIMEOUT_CYC wait cycles and flag bus_err.
module bus_ctrl_65c02
    import bus_pkg::*;
#(
    parameter int unsigned P2_DIV      = 4,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addr,
    input  logic        we,
    input  logic        ext_ack,
    output logic        rdy,
    output logic        ram_cs,
    output logic        rom_cs,
    output logic        acia_cs_n,
    output logic        via_cs2_n,
    output logic        ext_cs,
    output logic        via_p2_en,
    output bus_sel_t    rd_sel,
    output logic        bus_err
);

    localparam int unsigned CW = $clog2(P2_DIV);

    if (P2_DIV < 2 || P2_DIV > 16 || TIMEOUT_CYC < 2) begin : g_bad_params
        $error("bus_ctrl_65c02: P2_DIV must be 2..16 and TIMEOUT_CYC at least 2");
    end

    bus_sel_t   sel;
    bus_state_t state;
    logic [CW-1:0] p2_cnt;
    logic       fresh_rdy;
    logic       rdy_core;
    logic       timeout;

    bus_decode u_decode (
        .addr (addr),
        .sel  (sel)
    );

    assign ram_cs    = (sel == SEL_RAM);
    assign rom_cs    = (sel == SEL_ROM);
    assign acia_cs_n = (sel != SEL_ACIA);
    assign via_cs2_n = (sel != SEL_VIA);
    assign ext_cs    = (sel == SEL_EXT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p2_cnt <= '0;
        end else if (p2_cnt == CW'(P2_DIV - 1)) begin
            p2_cnt <= '0;
        end else begin
            p2_cnt <= p2_cnt + 1'b1;
        end
    end

    assign via_p2_en = (p2_cnt == CW'(P2_DIV - 1));

`ifdef BUS_TIMEOUT_EN
    localparam int unsigned WW = $clog2(TIMEOUT_CYC + 1);

    logic [WW-1:0] wait_cnt;
    logic          err_q;

    assign timeout = (state == ST_WAIT_EXT) && (sel == SEL_EXT) && !ext_ack &&
                     (wait_cnt == WW'(TIMEOUT_CYC - 1));

    // Any cycle outside a continuing external stall zeroes the counter, so it is clear on entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state == ST_WAIT_EXT && sel == SEL_EXT && !ext_ack && !timeout) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end
            if (timeout) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus_err = err_q;
`else
    assign timeout = 1'b0;
    assign bus_err = 1'b0;
`endif

    always_comb begin
        fresh_rdy = 1'b1;
        case (sel)
            SEL_VIA: fresh_rdy = via_p2_en;
            SEL_EXT: fresh_rdy = ext_ack;
            default: fresh_rdy = 1'b1;
        endcase
    end

    // A wait state whose region the address has left falls back to a fresh decode.
    always_comb begin
        rdy_core = fresh_rdy;
        case (state)
            ST_WAIT_VIA: rdy_core = (sel == SEL_VIA) ? via_p2_en : fresh_rdy;
            ST_WAIT_EXT: rdy_core = (sel == SEL_EXT) ? (ext_ack | timeout) : fresh_rdy;
            default:     rdy_core = fresh_rdy;
        endcase
    end

    assign rdy = rdy_core | reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            rd_sel <= SEL_NONE;
        end else if (rdy_core) begin
            state  <= ST_IDLE;
            rd_sel <= (we || timeout) ? SEL_NONE : sel;
        end else begin
            state  <= (sel == SEL_VIA) ? ST_WAIT_VIA : ST_WAIT_EXT;
        end
    end

endmodule

// File: tb/tb_bus_ctrl_65c02.sv
// tb/tb_bus_ctrl_65c02.sv - scoreboard bench for bus_ctrl_65c02 (P2_DIV=4, TIMEOUT_CYC=16)
module tb_bus_ctrl_65c02;
    import bus_pkg::*;

`ifdef BUS_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk     = 1'b0;
    logic        reset   = 1'b1;
    logic [15:0] addr    = 16'h0000;
    logic        we      = 1'b0;
    logic        ext_ack = 1'b0;
    logic        rdy, ram_cs, rom_cs, acia_cs_n, via_cs2_n, ext_cs, via_p2_en, bus_err;
    bus_sel_t    rd_sel;

    int       checks = 0;
    int       errors = 0;
    bus_sel_t exp_q[$];
    int       m_cnt  = 0;
    int       m_wcnt = 0;
    bit       m_inext = 1'b0;
    bit       m_err   = 1'b0;
    int       cyc     = 0;

    bus_ctrl_65c02 #(.P2_DIV(4), .TIMEOUT_CYC(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .addr      (addr),
        .we        (we),
        .ext_ack   (ext_ack),
        .rdy       (rdy),
        .ram_cs    (ram_cs),
        .rom_cs    (rom_cs),
        .acia_cs_n (acia_cs_n),
        .via_cs2_n (via_cs2_n),
        .ext_cs    (ext_cs),
        .via_p2_en (via_p2_en),
        .rd_sel    (rd_sel),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic bus_sel_t m_decode(input logic [15:0] a);
        if (a >= 16'hC000)                      return SEL_ROM;
        if (a < 16'h8000)                       return SEL_RAM;
        if (a <= 16'h800F)                      return SEL_ACIA;
        if (a >= 16'h8800 && a <= 16'h880F)     return SEL_VIA;
        return SEL_EXT;
    endfunction

    // One bus cycle: drive just after the rising edge, check at the falling edge.
    task automatic cycle(input logic [15:0] a, input logic w, input logic ack, output logic r_obs);
        bus_sel_t s;
        logic     p2, r_m, to_m;
        addr = a; we = w; ext_ack = ack;
        @(negedge clk);
        if (exp_q.size() > 0) check("rd_sel", rd_sel, exp_q.pop_front());
        s    = m_decode(a);
        p2   = (m_cnt == 3);
        to_m = TO_EN && m_inext && (s == SEL_EXT) && !ack && (m_wcnt == 15);
        case (s)
            SEL_VIA: r_m = p2;
            SEL_EXT: r_m = ack || to_m;
            default: r_m = 1'b1;
        endcase
        check("via_p2_en", via_p2_en, p2);
        check("rdy", rdy, r_m);
        check("ram_cs", ram_cs, s == SEL_RAM);
        check("rom_cs", rom_cs, s == SEL_ROM);
        check("acia_cs_n", acia_cs_n, s != SEL_ACIA);
        check("via_cs2_n", via_cs2_n, s != SEL_VIA);
        check("ext_cs", ext_cs, s == SEL_EXT);
        check("bus_err", bus_err, m_err);
        r_obs = rdy;
        if (to_m) m_err = 1'b1;
        if (r_m) exp_q.push_back((w || to_m) ? SEL_NONE : s);
        if (!r_m && s == SEL_EXT && m_inext) m_wcnt++;
        else m_wcnt = 0;
        m_inext = !r_m && (s == SEL_EXT);
        m_cnt = (m_cnt + 1) % 4;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_to(input int c);
        logic r;
        for (int i = 0; i < 4 && m_cnt != c; i++) cycle(16'h0000, 1'b0, 1'b0, r);
    endtask

    task automatic access(input logic [15:0] a, input logic w, output int lows);
        logic r;
        bit   done;
        lows = 0;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            cycle(a, w, 1'b0, r);
            if (r) done = 1'b1;
            else lows++;
        end
        if (!done) check("access_done", 0, 1);
    endtask

    initial begin
        logic r;
        int   lows;
        int   c1;

        repeat (2) @(posedge clk);
        #1;
        check("rst_rdy", rdy, 1);
        check("rst_rd_sel", rd_sel, SEL_NONE);
        check("rst_bus_err", bus_err, 0);
        check("rst_p2", via_p2_en, 0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) cycle(16'h0000, 1'b0, 1'b0, r);

        idle_to(0);
        access(16'h8803, 1'b0, lows);
        check("via_waits_cnt0", lows, 3);
        idle_to(3);
        access(16'h8803, 1'b0, lows);
        check("via_waits_cnt3", lows, 0);

        cycle(16'h0000, 1'b0, 1'b0, r);
        cycle(16'hC000, 1'b0, 1'b0, r);
        cycle(16'h800F, 1'b0, 1'b0, r);
        cycle(16'h7FFF, 1'b0, 1'b0, r);
        cycle(16'h0010, 1'b1, 1'b0, r);
        cycle(16'hFFFF, 1'b0, 1'b0, r);
        cycle(16'h8000, 1'b1, 1'b0, r);

        lows = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(16'h9000, 1'b0, i >= 5, r);
            if (!r) lows++;
        end
        check("ext_waits", lows, 5);
        cycle(16'h0000, 1'b0, 1'b0, r);

        idle_to(1);
        access(16'h8800, 1'b1, lows);
        c1 = cyc;
        access(16'h8801, 1'b1, lows);
        check("via_b2b_gap", cyc - c1, 4);

        idle_to(0);
        cycle(16'h8803, 1'b0, 1'b0, r);
        cycle(16'h1234, 1'b0, 1'b0, r);
        cycle(16'h880F, 1'b0, 1'b0, r);
        idle_to(0);
        cycle(16'h9000, 1'b0, 1'b0, r);
        cycle(16'hC123, 1'b0, 1'b0, r);

`ifdef BUS_TIMEOUT_EN
        access(16'h9000, 1'b0, lows);
        check("timeout_waits", lows, 16);
        for (int i = 0; i < 3; i++) cycle(16'h0000, 1'b0, 1'b0, r);
        check("bus_err_sticky", bus_err, 1);
`else
        lows = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(16'h9000, 1'b0, 1'b0, r);
            if (!r) lows++;
        end
        check("ext_no_timeout", lows, 20);
        cycle(16'h9000, 1'b0, 1'b1, r);
        cycle(16'h0000, 1'b0, 1'b0, r);
`endif

        idle_to(0);
        cycle(16'h8803, 1'b0, 1'b0, r);
        reset = 1'b1;
        #1;
        check("midwait_rst_rdy", rdy, 1);
        check("midwait_rst_rd_sel", rd_sel, SEL_NONE);
        check("midwait_rst_bus_err", bus_err, 0);
        check("midwait_rst_p2", via_p2_en, 0);
        @(posedge clk);
        #1;
        reset   = 1'b0;
        m_cnt   = 0;
        m_wcnt  = 0;
        m_inext = 1'b0;
        m_err   = 1'b0;
        exp_q.delete();
        access(16'h8803, 1'b0, lows);
        check("post_rst_via_waits", lows, 3);
        for (int i = 0; i < 8; i++) cycle(16'h0000, 1'b0, 1'b0, r);

        check("queue_drained", exp_q.size(), 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bus_ctrl_65c02.md
Name: bus_ctrl_65c02

Overview:
- Central bus sequencer for the 65C02 system.
- Decodes the CPU address into device selects for RAM, ROM, ACIA, VIA and an external expansion bus.
- Generates the VIA phase-2 clock enable and inserts RDY wait states for slow targets (VIA, external bus).
- Produces a registered read-mux select that the top level uses to steer device data onto the CPU DI bus.

Parameters:
- P2_DIV, 4: clk cycles per VIA phase-2 enable pulse; must be 2..16.
- TIMEOUT_CYC, 16: wait-state cycles before an external access is aborted; only used when BUS_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- addr  in  16  CPU address bus (AB).
- we  in  1  CPU write enable; 1 = write, 0 = read.
- ext_ack  in  1  external bus target completion, sampled on clk.
- rdy  out  1  to CPU RDY; 0 stalls the CPU.
- ram_cs  out  1  RAM enable, active high.
- rom_cs  out  1  ROM enable, active high.
- acia_cs_n  out  1  ACIA chip select, active low.
- via_cs2_n  out  1  VIA CS2, active low.
- ext_cs  out  1  external bus cycle in progress.
- via_p2_en  out  1  one-cycle VIA phase-2 enable.
- rd_sel  out  3  registered read source (bus_sel_t).
- bus_err  out  1  sticky timeout flag.

Behaviour:
- Decode (combinational from addr):
  - ROM: addr >= C000.
  - RAM: addr < 8000.
  - ACIA: 8000-800F.
  - VIA: 8800-880F.
  - EXT: every other address.
  - Exactly one region is hit at any time.
- Chip selects follow the decode combinationally and stay asserted during wait states.
- Reset values: rdy=1, rd_sel=SEL_NONE, via_p2_en=0, bus_err=0, state=IDLE, p2 counter=0. Chip selects are decode-driven and are not forced by reset.
- P2 counter: increments every clk and wraps at P2_DIV-1. via_p2_en=1 when the counter equals P2_DIV-1.
- FSM states: IDLE, WAIT_VIA, WAIT_EXT.
  - IDLE, VIA hit, via_p2_en=1: access completes this cycle with rdy=1; stay in IDLE.
  - IDLE, VIA hit, via_p2_en=0: rdy=0 combinationally; go to WAIT_VIA.
  - WAIT_VIA: rdy=0 until the cycle where via_p2_en=1. In that cycle rdy=1 and the FSM returns to IDLE.
  - IDLE, EXT hit, ext_ack=1: completes the same cycle.
  - IDLE, EXT hit, ext_ack=0: rdy=0; go to WAIT_EXT.
  - WAIT_EXT: rdy=0 until ext_ack=1, then rdy=1 and return to IDLE.
  - RAM, ROM and ACIA accesses: zero wait states; rdy=1.
  - Back-to-back VIA accesses are separate accesses: the second one waits for the next via_p2_en.
  - If addr leaves the waiting region mid-wait (illegal, since the CPU holds AB while RDY=0): return to IDLE and treat the cycle as a fresh decode.
- rdy path: rdy depends combinationally on addr, state, via_p2_en and ext_ack. The CPU's AB must not depend combinationally on RDY.
- rd_sel:
  - Registered on each clk where rdy=1 and we=0. Value is the decoded region; latency is 1 cycle, aligned with synchronous RAM/ROM output.
  - On a write cycle with rdy=1, it loads SEL_NONE.
  - While rdy=0, it holds its value.
  - The top level returns 8'hEA (NOP) for SEL_NONE.
- Reset mid-wait: the FSM goes to IDLE immediately and rdy=1 asynchronously.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to WAIT_EXT and increments each cycle in WAIT_EXT.
  - When it reaches TIMEOUT_CYC-1 without ext_ack, force rdy=1, return to IDLE, load rd_sel=SEL_NONE (CPU reads EA), and set bus_err=1.
  - bus_err is sticky; only reset clears it.
  - ext_ack arriving in the timeout cycle counts as a normal completion with no error.
- Undefined: no counter; WAIT_EXT can last indefinitely; bus_err is tied to 0.

Decomposition:
- Package bus_pkg holds:
  - bus_sel_t enum (3 bits): SEL_NONE=0, SEL_RAM, SEL_ROM, SEL_ACIA, SEL_VIA, SEL_EXT.
  - Region boundary constants: ROM_BASE, RAM_TOP, ACIA_BASE/ACIA_LAST, VIA_BASE/VIA_LAST.
  - FSM state enum.
- Sub-module: bus_decode (pure combinational addr -> bus_sel_t), reused by the top-level data mux.

Test Plan:
- Reset mid WAIT_VIA: assert reset -> rdy=1 the same cycle, rd_sel=0, bus_err=0, via_p2_en=0. After release, via_p2_en pulses every 4th clk.
- Read 0x8803 with the p2 counter at 0 -> rdy low for 3 cycles, high in the strobe cycle; rd_sel=SEL_VIA on the next edge. Read at counter=3 -> zero waits.
- Reads of 0x0000, 0xC000, 0x800F, 0x7FFF -> rdy stays 1; rd_sel = RAM, ROM, ACIA, RAM, each one cycle later. A write to 0x0010 -> rd_sel=SEL_NONE.
- Access to 0x9000 with ext_ack after 5 cycles -> ext_cs=1 and rdy=0 for exactly 5 cycles; rd_sel=SEL_EXT.
- BUS_TIMEOUT_EN, TIMEOUT_CYC=16, 0x9000 with ext_ack never asserted -> rdy returns high after 16 wait cycles; bus_err=1 and stays 1; rd_sel=SEL_NONE.
- Two consecutive VIA writes (0x8800, then 0x8801) -> each completes on its own via_p2_en pulse, 4 clk apart.
